// File: rtl/qs_enq_mb_pkg.sv
// Shared types and helpers for the quicksort multi-bank enqueue front-end.
// Bank state layout is {status, err, n}; n is entry count minus one.
package qs_enq_mb_pkg;

  typedef enum logic [2:0] {
    BANK_IDLE      = 3'd0,
    BANK_LOADING   = 3'd1,
    BANK_READY     = 3'd2,
    BANK_SORTING   = 3'd3,
    BANK_UNLOADING = 3'd4
  } bank_status_t;

  localparam int STATUS_W = 3;

  // Width of an index over v items, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int bank_state_w(input int n);
    return STATUS_W + 1 + clog2_min1(n);
  endfunction

  // Wraps by comparison so non-power-of-two bank counts stay in range.
  function automatic int bank_id_inc(input int id, input int banks_n);
    if (id >= banks_n - 1) return 0;
    return id + 1;
  endfunction

endpackage

// File: rtl/qs_enq_mb.sv
// Round-robin bank claimer and packet writer feeding the quicksort banks.
// Overlong or badly framed packets are drained and the bank is published with err set.
module qs_enq_mb
  import qs_enq_mb_pkg::*;
#(
  parameter int W       = 32,
  parameter int N       = 16,
  parameter int BANKS_N = 4,
  localparam int AW     = clog2_min1(N),
  localparam int BW     = clog2_min1(BANKS_N),
  localparam int SW     = bank_state_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [W-1:0]  in_dat,
  output logic          in_rdy,
  input  logic [SW-1:0] bnk_in,
  output logic          bnk_out_vld_r,
  output logic [SW-1:0] bnk_out_r,
  output logic [BW-1:0] bnk_idx_r,
  output logic          enq_wr_en_r,
  output logic [BW-1:0] enq_wr_bnk_r,
  output logic [AW-1:0] enq_wr_addr_r,
  output logic [W-1:0]  enq_wr_data_r
);

  typedef logic [BW-1:0] bank_id_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [W-1:0]  w_t;

  typedef struct packed {
    bank_status_t status;
    logic         err;
    addr_t        n;
  } bank_state_t;

  // Bit 0 of the state code is in_rdy.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_DRAIN = 2'b11
  } state_t;

  localparam addr_t LAST = addr_t'(N - 1);

  state_t      state_r, state_n;
  addr_t       idx_r, idx_n;
  logic        err_r, err_n;
  logic        full_r, full_n;
  bank_id_t    bidx_n;
  logic        wr_en_n;
  addr_t       wr_addr_n;
  w_t          wr_data_n;
  bank_id_t    wr_bnk_n;
  logic        bvld_n;
  bank_state_t bout_n;

  bank_status_t cur_status;
  logic         unused_bnk_bits;
  logic         accept;
  logic         beat_err;
  bank_id_t     bidx_inc;

  assign cur_status      = bank_status_t'(bnk_in[SW-1 -: STATUS_W]);
  assign unused_bnk_bits = ^bnk_in[SW-STATUS_W-1:0];
  assign in_rdy          = state_r[0];
  assign accept          = in_vld & in_rdy;
  assign beat_err        = (idx_r == '0) ? ~in_sop : in_sop;
  assign bidx_inc        = bank_id_t'(bank_id_inc(int'(bnk_idx_r), BANKS_N));

  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    err_n     = err_r;
    full_n    = full_r;
    bidx_n    = bnk_idx_r;
    wr_en_n   = 1'b0;
    wr_addr_n = enq_wr_addr_r;
    wr_data_n = enq_wr_data_r;
    wr_bnk_n  = enq_wr_bnk_r;
    bvld_n    = 1'b0;
    bout_n    = bank_state_t'(bnk_out_r);

    unique case (state_r)
      S_IDLE: begin
        if (cur_status == BANK_IDLE) begin
          bvld_n  = 1'b1;
          bout_n  = '{status: BANK_LOADING, err: 1'b0, n: '0};
          idx_n   = '0;
          err_n   = 1'b0;
          full_n  = 1'b0;
          state_n = S_LOAD;
        end
      end

      S_LOAD: begin
        if (accept) begin
          wr_en_n   = 1'b1;
          wr_addr_n = idx_r;
          wr_data_n = in_dat;
          wr_bnk_n  = bnk_idx_r;
          err_n     = err_r | beat_err;
          if (in_eop) begin
            bvld_n  = 1'b1;
            bout_n  = '{status: BANK_READY, err: err_r | beat_err, n: idx_r};
            bidx_n  = bidx_inc;
            state_n = S_IDLE;
          end else if (idx_r == LAST) begin
            full_n  = 1'b1;
            state_n = S_DRAIN;
          end else begin
            idx_n = idx_r + addr_t'(1);
          end
        end
      end

      S_DRAIN: begin
        err_n = 1'b1;
        if (accept && in_eop) begin
          bvld_n  = 1'b1;
          bout_n  = '{status: BANK_READY, err: err_r | full_r, n: LAST};
          bidx_n  = bidx_inc;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      idx_r         <= '0;
      err_r         <= 1'b0;
      full_r        <= 1'b0;
      bnk_idx_r     <= '0;
      bnk_out_vld_r <= 1'b0;
      bnk_out_r     <= '0;
      enq_wr_en_r   <= 1'b0;
      enq_wr_bnk_r  <= '0;
      enq_wr_addr_r <= '0;
      enq_wr_data_r <= '0;
    end else begin
      state_r       <= state_n;
      idx_r         <= idx_n;
      err_r         <= err_n;
      full_r        <= full_n;
      bnk_idx_r     <= bidx_n;
      bnk_out_vld_r <= bvld_n;
      bnk_out_r     <= bout_n;
      enq_wr_en_r   <= wr_en_n;
      enq_wr_bnk_r  <= wr_bnk_n;
      enq_wr_addr_r <= wr_addr_n;
      enq_wr_data_r <= wr_data_n;
    end
  end

endmodule
